// File: rtl/spwm_pkg.sv
// Shared definitions for the multi-channel SPWM generator: amplitude scale,
// controller states and an elaboration-time log2 helper.
package spwm_pkg;

   localparam logic [8:0] AMP_FULL = 9'd256;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } spwm_state_e;

   function automatic int clog2(input int value);
      int res;
      res = 32'sd0;
      while ((32'sd1 << res) < value) begin
         res = res + 32'sd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/spwm_qsine_rom.sv
// Quarter-wave sine table scaled to the carrier period, built at elaboration
// with integer fixed-point arithmetic, read through a one-cycle register.
module spwm_qsine_rom
   import spwm_pkg::*;
#(
   parameter int PERIOD = 5000,
   parameter int QSTEPS = 44,
   parameter int CNT_W  = 13,
   parameter int AW     = clog2(QSTEPS + 1)
) (
   input  logic             clk_i,
   input  logic [AW-1:0]    addr_i,
   output logic [CNT_W-1:0] data_o
);

   logic [CNT_W-1:0] tbl_s [QSTEPS+1];
   logic [CNT_W-1:0] data_q;

   // round(PERIOD * sin(pi/2 * k / QSTEPS)) via a Q30 Taylor series.
   function automatic longint qsine_val(input int k);
      longint x;
      longint x2;
      longint term;
      longint sum;
      x    = (64'sd3373259426 * longint'(k)) / longint'(2 * QSTEPS);
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 32'sd1; n <= 32'sd10; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      return (longint'(PERIOD) * sum + 64'sd536870912) >>> 30;
   endfunction

   for (genvar k = 0; k <= QSTEPS; k++) begin : g_tbl
      localparam longint VAL = qsine_val(k);
      assign tbl_s[k] = CNT_W'(VAL);
   end

   // Registered table read.
   always_ff @(posedge clk_i) begin
      if (int'(addr_i) <= QSTEPS) begin
         data_q <= tbl_s[addr_i];
      end else begin
         data_q <= '0;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/spwm_multi.sv
// Multi-channel sinusoidal PWM: shared carrier and half-wave phase stepping,
// per-channel phase offset, shared amplitude and optional gap between half waves.
module spwm_multi
   import spwm_pkg::*;
#(
   parameter int                     N_CH          = 2,
   parameter int                     PERIOD        = 5000,
   parameter int                     CNT_W         = 13,
   parameter int                     QSTEPS        = 44,
   parameter int                     TH_W          = 10,
   parameter int                     CARR_PER_STEP = 1,
   parameter int                     GAP_W         = 20,
   parameter logic [N_CH*TH_W-1:0]   PHASE_OFS     = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [8:0]       amp,
   input  logic [GAP_W-1:0] gap_len,
   output logic [N_CH-1:0]  pwm,
   output logic [TH_W-1:0]  theta_o,
   output logic             cycle_done
);

   localparam int HALF = 2 * QSTEPS;
   localparam int AW   = clog2(QSTEPS + 1);
   localparam int SW   = (CARR_PER_STEP > 1) ? clog2(CARR_PER_STEP) : 1;
   localparam int PW   = CNT_W + 9;

   spwm_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    step_q, step_d;
   logic [TH_W-1:0]  theta_q, theta_d, th_next_s;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d, gap_len_q, gap_len_d;
   logic             cycle_done_q, cycle_done_d;
   logic [N_CH-1:0]  pwm_q, pwm_d;
   logic [8:0]       amp_c_s;
   logic             wrap_s, step_last_s, period_start_s;

   assign wrap_s         = (cnt_q == CNT_W'(PERIOD - 1));
   assign step_last_s    = (step_q == SW'(CARR_PER_STEP - 1));
   assign period_start_s = (state_q == ST_IDLE) || wrap_s;
   assign amp_c_s        = (amp > AMP_FULL) ? AMP_FULL : amp;

   // Theta of the upcoming period, looked ahead so the ROM read lands before cnt=0.
   always_comb begin
      th_next_s = '0;
      if (rst || !en) begin
         th_next_s = '0;
      end else if (state_q == ST_RUN && step_last_s) begin
         if (theta_q == TH_W'(HALF - 1)) begin
            th_next_s = '0;
         end else begin
            th_next_s = theta_q + TH_W'(1);
         end
      end else if (state_q == ST_RUN) begin
         th_next_s = theta_q;
      end else begin
         th_next_s = '0;
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [TH_W:0]    sum_s;
      logic [TH_W-1:0]  th_c_s;
      logic [AW-1:0]    addr_s;
      logic [CNT_W-1:0] rom_s, duty_q, duty_d;
      logic [PW-1:0]    prod_s;

      // Channel phase wrap and half-wave fold onto the quarter table.
      always_comb begin
         sum_s = {1'b0, th_next_s} + {1'b0, PHASE_OFS[c*TH_W +: TH_W]};
         if (sum_s >= (TH_W+1)'(HALF)) begin
            th_c_s = TH_W'(sum_s - (TH_W+1)'(HALF));
         end else begin
            th_c_s = sum_s[TH_W-1:0];
         end
         if (th_c_s <= TH_W'(QSTEPS)) begin
            addr_s = AW'(th_c_s);
         end else begin
            addr_s = AW'(TH_W'(HALF) - th_c_s);
         end
      end

      spwm_qsine_rom #(
         .PERIOD (PERIOD),
         .QSTEPS (QSTEPS),
         .CNT_W  (CNT_W),
         .AW     (AW)
      ) u_rom (
         .clk_i  (clk),
         .addr_i (addr_s),
         .data_o (rom_s)
      );

      // Scaled duty, taken only when a new carrier period begins.
      always_comb begin
         prod_s = PW'(rom_s) * PW'(amp_c_s);
         if (period_start_s) begin
            duty_d = CNT_W'(prod_s >> 4'd8);
         end else begin
            duty_d = duty_q;
         end
      end

      // Per-channel duty register.
      always_ff @(posedge clk) begin
         if (rst) begin
            duty_q <= '0;
         end else begin
            duty_q <= duty_d;
         end
      end

      assign pwm_d[c] = (state_d == ST_RUN) && (cnt_d < duty_d);
   end

   // Controller next state: carrier, phase step, gap and half-wave completion.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      step_d       = step_q;
      theta_d      = theta_q;
      gap_cnt_d    = gap_cnt_q;
      gap_len_d    = gap_len_q;
      cycle_done_d = 1'b0;
      if (!en) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         step_d    = '0;
         theta_d   = '0;
         gap_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_RUN;
               cnt_d   = '0;
               step_d  = '0;
               theta_d = '0;
            end
            ST_RUN: begin
               if (!wrap_s) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  cnt_d = '0;
                  if (!step_last_s) begin
                     step_d = step_q + SW'(1);
                  end else begin
                     step_d = '0;
                     if (theta_q != TH_W'(HALF - 1)) begin
                        theta_d = theta_q + TH_W'(1);
                     end else begin
                        theta_d      = '0;
                        cycle_done_d = 1'b1;
                        if (gap_len != '0) begin
                           state_d   = ST_GAP;
                           gap_len_d = gap_len;
                           gap_cnt_d = '0;
                        end else begin
                           state_d = ST_RUN;
                        end
                     end
                  end
               end
            end
            ST_GAP: begin
               theta_d = '0;
               if (!wrap_s) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  cnt_d = '0;
                  if (gap_cnt_q == gap_len_q - GAP_W'(1)) begin
                     state_d   = ST_RUN;
                     gap_cnt_d = '0;
                     step_d    = '0;
                  end else begin
                     gap_cnt_d = gap_cnt_q + GAP_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               step_d  = '0;
               theta_d = '0;
            end
         endcase
      end
   end

   // Controller and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         step_q       <= '0;
         theta_q      <= '0;
         gap_cnt_q    <= '0;
         gap_len_q    <= '0;
         cycle_done_q <= 1'b0;
         pwm_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         step_q       <= step_d;
         theta_q      <= theta_d;
         gap_cnt_q    <= gap_cnt_d;
         gap_len_q    <= gap_len_d;
         cycle_done_q <= cycle_done_d;
         pwm_q        <= pwm_d;
      end
   end

   assign pwm        = pwm_q;
   assign theta_o    = theta_q;
   assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_spwm_multi.sv
// Scoreboard bench for spwm_multi: a period-level reference model predicts every
// output cycle; a monitor compares DUT outputs against the queued predictions.
module tb_spwm_multi;

   localparam int P  = 100;
   localparam int Q  = 4;
   localparam int NC = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [8:0] amp;
   logic [7:0] gap_len;
   logic [1:0] pwm;
   logic [3:0] theta_o;
   logic       cycle_done;

   typedef struct packed {
      logic [1:0] pwm;
      logic [3:0] th;
      logic       cd;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   int tbl[Q+1] = '{0, 38, 71, 92, 100};
   int ofs[NC]  = '{0, 4};

   bit m_active = 1'b0;
   int m_t      = 0;
   int m_j      = 0;
   int m_glen   = 0;
   int m_amp    = 0;

   spwm_multi #(
      .N_CH          (NC),
      .PERIOD        (P),
      .CNT_W         (7),
      .QSTEPS        (Q),
      .TH_W          (4),
      .CARR_PER_STEP (1),
      .GAP_W         (8),
      .PHASE_OFS     ({4'd4, 4'd0})
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .amp        (amp),
      .gap_len    (gap_len),
      .pwm        (pwm),
      .theta_o    (theta_o),
      .cycle_done (cycle_done)
   );

   always #5 clk = ~clk;

   function automatic int sine(input int i);
      return (i <= Q) ? tbl[i] : tbl[2*Q - i];
   endfunction

   function automatic int clamp_amp(input int a);
      return (a > 256) ? 256 : a;
   endfunction

   // Advance the model across one clock edge using the current inputs.
   task automatic model_edge(output exp_t x);
      bit         cd;
      logic [1:0] p;
      int         k;
      int         duty;
      cd = 1'b0;
      p  = 2'b00;
      if (rst || !en) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         m_active = 1'b1;
         m_t      = 0;
         m_j      = 0;
         m_amp    = clamp_amp(int'(amp));
      end else begin
         m_t++;
         if (m_t % P == 0) begin
            m_amp = clamp_amp(int'(amp));
            m_j++;
            if (m_j == 2*Q) begin
               cd     = 1'b1;
               m_glen = int'(gap_len);
               if (m_glen == 0) m_j = 0;
            end else if (m_j == 2*Q + m_glen) begin
               m_j = 0;
            end
         end
      end
      x.cd = cd;
      if (m_active && m_j < 2*Q) begin
         k = m_t % P;
         for (int c = 0; c < NC; c++) begin
            duty = (sine((m_j + ofs[c]) % (2*Q)) * m_amp) / 256;
            p[c] = (k < duty);
         end
         x.th = 4'(m_j);
      end else begin
         x.th = 4'd0;
      end
      x.pwm = p;
   endtask

   task automatic step(input int n);
      exp_t x;
      for (int i = 0; i < n; i++) begin
         model_edge(x);
         @(posedge clk);
         #1;
         sb_q.push_back(x);
      end
   endtask

   // Monitor: every output cycle is checked against the oldest prediction.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         total++;
         if (pwm !== e.pwm) begin
            bad++;
            $display("FAIL pwm t=%0t got=%b exp=%b", $time, pwm, e.pwm);
         end
         total++;
         if (theta_o !== e.th) begin
            bad++;
            $display("FAIL theta t=%0t got=%0d exp=%0d", $time, theta_o, e.th);
         end
         total++;
         if (cycle_done !== e.cd) begin
            bad++;
            $display("FAIL cycle_done t=%0t got=%b exp=%b", $time, cycle_done, e.cd);
         end
      end
   end

   initial begin
      rst     = 1'b1;
      en      = 1'b1;
      amp     = 9'd256;
      gap_len = 8'd0;
      step(3);
      rst = 1'b0;
      step(1700);
      amp = 9'd128;
      step(900);
      amp = 9'd400;
      step(900);
      en = 1'b0;
      step(2);
      en  = 1'b1;
      amp = 9'd256;
      step(251);
      en = 1'b0;
      step(3);
      en = 1'b1;
      step(330);
      amp = 9'd300;
      step(300);
      gap_len = 8'd3;
      step(2400);
      gap_len = 8'd0;
      step(200);
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 149) == 0) amp = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 299) == 0) gap_len = 8'($urandom_range(0, 3));
         if (!en) begin
            if ($urandom_range(0, 2) == 0) en = 1'b1;
         end else if ($urandom_range(0, 699) == 0) begin
            en = 1'b0;
         end
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(0, 1499) == 0) begin
            rst = 1'b1;
         end
         step(1);
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d exp=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
